// File: rtl/core_wb_arbiter_pkg.sv
// Shared types for the instruction/data Wishbone arbiter: FSM states, grant
// encoding and the all-ones read value used at reset and on watchdog abort.
package core_wb_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_INSTR = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_t;

    localparam logic [31:0] READ_DEFAULT = 32'hFFFF_FFFF;

    // On a tie the requester that was not served last wins.
    function automatic grant_t pick_grant(input logic instr_req, input logic data_req,
                                          input grant_t last_grant);
        if (instr_req && data_req)
            return (last_grant == GRANT_INSTR) ? GRANT_DATA : GRANT_INSTR;
        else if (data_req)
            return GRANT_DATA;
        else
            return GRANT_INSTR;
    endfunction

endpackage

// File: rtl/core_wb_arbiter_if.sv
// Requester-side and downstream-side signals of the arbiter. The master modport
// is the arbiter's view; slave is the view of the requesters plus memory side.
interface core_wb_arbiter_if #(
    parameter int unsigned ADDRESS_WIDTH = 28
);
    logic [ADDRESS_WIDTH-1:0] instrAddress;
    logic [3:0]               instrByteSelect;
    logic                     instrEnable;
    logic                     instrWriteEnable;
    logic [31:0]              instrDataWrite;
    logic [31:0]              instrDataRead;
    logic                     instrAck;
    logic                     instrError;

    logic [ADDRESS_WIDTH-1:0] dataAddress;
    logic [3:0]               dataByteSelect;
    logic                     dataEnable;
    logic                     dataWriteEnable;
    logic [31:0]              dataDataWrite;
    logic [31:0]              dataDataRead;
    logic                     dataAck;
    logic                     dataError;

    logic [ADDRESS_WIDTH-1:0] wbAddress;
    logic [3:0]               wbByteSelect;
    logic                     wbWriteEnable;
    logic [31:0]              wbDataWrite;
    logic                     wbEnable;
    logic [31:0]              wbDataRead;
    logic                     wbBusy;

    modport master (
        input  instrAddress, instrByteSelect, instrEnable, instrWriteEnable, instrDataWrite,
        output instrDataRead, instrAck, instrError,
        input  dataAddress, dataByteSelect, dataEnable, dataWriteEnable, dataDataWrite,
        output dataDataRead, dataAck, dataError,
        output wbAddress, wbByteSelect, wbWriteEnable, wbDataWrite, wbEnable,
        input  wbDataRead, wbBusy
    );

    modport slave (
        output instrAddress, instrByteSelect, instrEnable, instrWriteEnable, instrDataWrite,
        input  instrDataRead, instrAck, instrError,
        output dataAddress, dataByteSelect, dataEnable, dataWriteEnable, dataDataWrite,
        input  dataDataRead, dataAck, dataError,
        input  wbAddress, wbByteSelect, wbWriteEnable, wbDataWrite, wbEnable,
        output wbDataRead, wbBusy
    );

endinterface

// File: rtl/core_wb_arbiter_watchdog.sv
// 8-bit transaction watchdog: cleared at transaction start, counts while enabled,
// flags expiry when the count reaches TIMEOUT_CYCLES (0 disables it).
module core_wb_arbiter_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] count_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            count_q <= '0;
        else if (clear)
            count_q <= '0;
        else if (enable && (count_q != '1))
            count_q <= count_q + 8'd1;
    end

    assign expired = (LIMIT != '0) && (count_q == LIMIT);

endmodule

// File: rtl/core_wb_arbiter.sv
// Round-robin arbiter sharing one single-beat downstream Wishbone port between
// the instruction-fetch and data-memory requesters, with watchdog abort.
module core_wb_arbiter #(
    parameter int unsigned ADDRESS_WIDTH  = 28,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    core_wb_arbiter_if.master  bus
);
    import core_wb_arbiter_pkg::*;

    arb_state_t               state_q, state_d;
    grant_t                   grant_q, last_grant_q;
    logic                     err_q, abort_q;
    logic                     complete, done_err, done_abort;
    logic                     req_any, granted_en, granted_we;
    logic                     wd_clear, wd_run, wd_expired;
    logic [31:0]              instr_rd_q, data_rd_q;
    logic [ADDRESS_WIDTH-1:0] addr_mux;

    assign req_any    = bus.instrEnable | bus.dataEnable;
    assign granted_en = (grant_q == GRANT_DATA) ? bus.dataEnable      : bus.instrEnable;
    assign granted_we = (grant_q == GRANT_DATA) ? bus.dataWriteEnable : bus.instrWriteEnable;

    assign wd_clear = (state_q == ST_IDLE) && req_any;
    assign wd_run   = (state_q == ST_START) || (state_q == ST_ACTIVE);

    core_wb_arbiter_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .clear    (wd_clear),
        .enable   (wd_run),
        .expired  (wd_expired)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Requester withdrawal beats watchdog expiry, which beats normal completion.
    always_comb begin
        state_d    = state_q;
        complete   = 1'b0;
        done_err   = 1'b0;
        done_abort = 1'b0;
        unique case (state_q)
            ST_IDLE:
                if (req_any) state_d = ST_START;
            ST_START, ST_ACTIVE: begin
                if (!granted_en) begin
                    state_d    = ST_DONE;
                    done_abort = 1'b1;
                end else if (wd_expired) begin
                    state_d  = ST_DONE;
                    done_err = 1'b1;
                end else if ((state_q == ST_START) && bus.wbBusy) begin
                    state_d = ST_ACTIVE;
                end else if ((state_q == ST_ACTIVE) && !bus.wbBusy) begin
                    state_d  = ST_DONE;
                    complete = 1'b1;
                end
            end
            ST_DONE:
                state_d = ST_IDLE;
            default:
                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.wbEnable   = 1'b0;
        bus.instrAck   = 1'b0;
        bus.dataAck    = 1'b0;
        bus.instrError = 1'b0;
        bus.dataError  = 1'b0;
        unique case (state_q)
            ST_START, ST_ACTIVE:
                bus.wbEnable = 1'b1;
            ST_DONE:
                if (!abort_q) begin
                    if (grant_q == GRANT_DATA) begin
                        bus.dataAck   = 1'b1;
                        bus.dataError = err_q;
                    end else begin
                        bus.instrAck   = 1'b1;
                        bus.instrError = err_q;
                    end
                end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            grant_q      <= GRANT_INSTR;
            last_grant_q <= GRANT_INSTR;
            err_q        <= 1'b0;
            abort_q      <= 1'b0;
            instr_rd_q   <= READ_DEFAULT;
            data_rd_q    <= READ_DEFAULT;
        end else begin
            if ((state_q == ST_IDLE) && req_any)
                grant_q <= pick_grant(bus.instrEnable, bus.dataEnable, last_grant_q);
            if (state_q == ST_DONE)
                last_grant_q <= grant_q;
            if (complete || done_err || done_abort) begin
                err_q   <= done_err;
                abort_q <= done_abort;
            end
            if (done_err) begin
                if (grant_q == GRANT_DATA) data_rd_q  <= READ_DEFAULT;
                else                       instr_rd_q <= READ_DEFAULT;
            end else if (complete && !granted_we) begin
                if (grant_q == GRANT_DATA) data_rd_q  <= bus.wbDataRead;
                else                       instr_rd_q <= bus.wbDataRead;
            end
        end
    end

    assign bus.instrDataRead = instr_rd_q;
    assign bus.dataDataRead  = data_rd_q;

    assign addr_mux          = (grant_q == GRANT_DATA) ? bus.dataAddress     : bus.instrAddress;
    assign bus.wbAddress     = addr_mux;
    assign bus.wbByteSelect  = (grant_q == GRANT_DATA) ? bus.dataByteSelect  : bus.instrByteSelect;
    assign bus.wbWriteEnable = granted_we;
    assign bus.wbDataWrite   = (grant_q == GRANT_DATA) ? bus.dataDataWrite   : bus.instrDataWrite;

endmodule

// File: tb/tb_core_wb_arbiter.sv
// Directed bench for core_wb_arbiter: a vector table of single transactions plus
// hand-written tie, watchdog, reset and withdrawal sequences.
module tb_core_wb_arbiter;

    localparam int unsigned AW  = 28;
    localparam int unsigned TMO = 16;

    typedef struct {
        logic        is_data;
        logic        we;
        logic [27:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] resp;
        int unsigned waits;
        int unsigned exp_ack;
        logic [31:0] exp_rd;
    } vec_t;

    logic wb_clk_i = 1'b0;
    logic wb_rst_i = 1'b1;
    always #5 wb_clk_i = ~wb_clk_i;

    core_wb_arbiter_if #(.ADDRESS_WIDTH(AW)) bus();

    core_wb_arbiter #(
        .ADDRESS_WIDTH  (AW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .bus      (bus)
    );

    // Downstream model: starts on wbEnable, drops busy after the wait states,
    // aborts when wbEnable falls, ignores the start sampled at completion.
    logic        s_busy  = 1'b0;
    logic        s_cool  = 1'b0;
    logic        s_hang  = 1'b0;
    int unsigned s_left  = 0;
    int unsigned s_waits = 0;
    logic [31:0] s_resp  = '0;
    logic [31:0] s_rdata = '0;

    assign bus.wbBusy     = s_busy;
    assign bus.wbDataRead = s_rdata;

    always @(posedge wb_clk_i) begin
        if (s_busy) begin
            if (!bus.wbEnable) begin
                s_busy <= 1'b0;
            end else if (!s_hang) begin
                if (s_left == 0) begin
                    s_busy  <= 1'b0;
                    s_rdata <= s_resp;
                    s_cool  <= 1'b1;
                end else begin
                    s_left <= s_left - 1;
                end
            end
        end else begin
            if (!bus.wbEnable)
                s_cool <= 1'b0;
            else if (!s_cool) begin
                s_busy <= 1'b1;
                s_left <= s_waits;
            end
        end
    end

    int unsigned n_checks = 0;
    int unsigned n_err    = 0;

    logic [63:0] en_hist;
    logic [27:0] f_addr;
    logic [3:0]  f_sel;
    logic [31:0] f_wdata;
    logic        f_we;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic is_data, input logic we, input logic [27:0] addr,
                                input logic [3:0] sel, input logic [31:0] wdata,
                                input logic [31:0] resp, input int unsigned waits,
                                input int unsigned exp_ack, input logic [31:0] exp_rd);
        vec_t v;
        v.is_data = is_data; v.we = we; v.addr = addr; v.sel = sel; v.wdata = wdata;
        v.resp = resp; v.waits = waits; v.exp_ack = exp_ack; v.exp_rd = exp_rd;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        s_resp  = v.resp;
        s_waits = v.waits;
        if (v.is_data) begin
            bus.dataAddress = v.addr; bus.dataByteSelect = v.sel;
            bus.dataWriteEnable = v.we; bus.dataDataWrite = v.wdata; bus.dataEnable = 1'b1;
        end else begin
            bus.instrAddress = v.addr; bus.instrByteSelect = v.sel;
            bus.instrWriteEnable = v.we; bus.instrDataWrite = v.wdata; bus.instrEnable = 1'b1;
        end
    endtask

    // Returns the cycle of the requester's Ack (0 if the budget ran out), counting
    // the request cycle as 0; drops the request as soon as the Ack is seen.
    task automatic wait_ack(input logic is_data, input int unsigned budget,
                            output int unsigned cyc, output logic err, output logic other);
        cyc = 0; err = 1'b0; other = 1'b0; en_hist = '0;
        for (int unsigned c = 1; c <= budget; c++) begin
            @(posedge wb_clk_i); #1;
            if (c < 64) en_hist[c[5:0]] = bus.wbEnable;
            if (c == 1) begin
                f_addr = bus.wbAddress; f_sel = bus.wbByteSelect;
                f_wdata = bus.wbDataWrite; f_we = bus.wbWriteEnable;
            end
            if (is_data ? bus.instrAck : bus.dataAck) other = 1'b1;
            if (is_data ? bus.dataAck : bus.instrAck) begin
                cyc = c;
                err = is_data ? bus.dataError : bus.instrError;
                if (is_data) bus.dataEnable = 1'b0;
                else         bus.instrEnable = 1'b0;
                break;
            end
        end
    endtask

    task automatic tie(input logic exp_data_first, input logic [31:0] r1,
                       input logic [31:0] r2, input string tag);
        int unsigned c_first;
        int unsigned c_second;
        logic        first_is_data;
        logic        got_first;
        c_first = 0; c_second = 0; first_is_data = 1'b0; got_first = 1'b0;
        @(posedge wb_clk_i); #1;
        bus.instrWriteEnable = 1'b0; bus.dataWriteEnable = 1'b0;
        bus.instrAddress = 28'h0000040; bus.dataAddress = 28'h0000100;
        s_resp = r1; s_waits = 0;
        bus.instrEnable = 1'b1; bus.dataEnable = 1'b1;
        for (int unsigned c = 1; c <= 30; c++) begin
            @(posedge wb_clk_i); #1;
            if (c == 1)
                check({tag, " first_grant_addr"}, 32'(bus.wbAddress),
                      exp_data_first ? 32'h0000100 : 32'h0000040);
            if (bus.dataAck || bus.instrAck) begin
                if (!got_first) begin
                    got_first = 1'b1; first_is_data = bus.dataAck; c_first = c;
                    check({tag, " first_rd"}, bus.dataAck ? bus.dataDataRead : bus.instrDataRead, r1);
                    s_resp = r2;
                end else begin
                    c_second = c;
                    check({tag, " second_is_data"}, 32'(bus.dataAck), 32'(!exp_data_first));
                    check({tag, " second_rd"}, bus.dataAck ? bus.dataDataRead : bus.instrDataRead, r2);
                end
                if (bus.dataAck) bus.dataEnable = 1'b0;
                else             bus.instrEnable = 1'b0;
            end
            if (c_second != 0) break;
        end
        check({tag, " first_is_data"}, 32'(first_is_data), 32'(exp_data_first));
        check({tag, " first_ack_cycle"}, c_first, 32'd4);
        check({tag, " second_ack_cycle"}, c_second, 32'd9);
        bus.instrEnable = 1'b0; bus.dataEnable = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    vec_t        vt [6];
    vec_t        fresh;
    int unsigned cyc;
    logic        err;
    logic        other;
    logic        seen;

    initial begin
        vt[0] = mk(1'b1, 1'b0, 28'h0000100, 4'hF,    32'h0,        32'hDEADBEEF, 0, 4, 32'hDEADBEEF);
        vt[1] = mk(1'b0, 1'b1, 28'h0000A00, 4'b0011, 32'h12345678, 32'h99999999, 3, 7, 32'h55AA0004);
        vt[2] = mk(1'b0, 1'b0, 28'h0000A04, 4'hF,    32'h0,        32'h0BADF00D, 1, 5, 32'h0BADF00D);
        vt[3] = mk(1'b1, 1'b1, 28'h0000104, 4'b1100, 32'hCAFEF00D, 32'h88888888, 2, 6, 32'hDEADBEEF);
        vt[4] = mk(1'b0, 1'b1, 28'hFFFFFFF, 4'b1000, 32'h00C0FFEE, 32'h77777777, 0, 4, 32'h0BADF00D);
        vt[5] = mk(1'b1, 1'b0, 28'h0000000, 4'hF,    32'h0,        32'hA5A55A5A, 0, 4, 32'hA5A55A5A);

        bus.instrAddress = 28'h0AAAAAA; bus.instrByteSelect = 4'hF; bus.instrEnable = 1'b0;
        bus.instrWriteEnable = 1'b0; bus.instrDataWrite = '0;
        bus.dataAddress = 28'h0555555; bus.dataByteSelect = 4'hF; bus.dataEnable = 1'b0;
        bus.dataWriteEnable = 1'b0; bus.dataDataWrite = '0;

        repeat (3) @(posedge wb_clk_i);
        #1;
        check("reset wbEnable",      32'(bus.wbEnable),   32'd0);
        check("reset instrAck",      32'(bus.instrAck),   32'd0);
        check("reset dataAck",       32'(bus.dataAck),    32'd0);
        check("reset instrError",    32'(bus.instrError), 32'd0);
        check("reset dataError",     32'(bus.dataError),  32'd0);
        check("reset instrDataRead", bus.instrDataRead,   32'hFFFFFFFF);
        check("reset dataDataRead",  bus.dataDataRead,    32'hFFFFFFFF);
        check("reset wbAddress",     32'(bus.wbAddress),  32'h0AAAAAA);
        wb_rst_i = 1'b0;

        tie(1'b1, 32'h55AA0001, 32'h55AA0002, "tie1");
        tie(1'b1, 32'h55AA0003, 32'h55AA0004, "tie2");

        for (int i = 0; i < 6; i++) begin
            @(posedge wb_clk_i); #1;
            drive(vt[i]);
            wait_ack(vt[i].is_data, 40, cyc, err, other);
            check($sformatf("v%0d ack_cycle", i), cyc, vt[i].exp_ack);
            check($sformatf("v%0d error", i), 32'(err), 32'd0);
            check($sformatf("v%0d other_ack", i), 32'(other), 32'd0);
            check($sformatf("v%0d wbAddress", i), 32'(f_addr), 32'(vt[i].addr));
            check($sformatf("v%0d wbByteSelect", i), 32'(f_sel), 32'(vt[i].sel));
            check($sformatf("v%0d wbWriteEnable", i), 32'(f_we), 32'(vt[i].we));
            if (vt[i].we)
                check($sformatf("v%0d wbDataWrite", i), f_wdata, vt[i].wdata);
            check($sformatf("v%0d wbEnable_start", i), 32'(en_hist[1]), 32'd1);
            if (cyc > 0 && cyc < 64)
                check($sformatf("v%0d wbEnable_done", i), 32'(en_hist[cyc[5:0]]), 32'd0);
            check($sformatf("v%0d DataRead", i),
                  vt[i].is_data ? bus.dataDataRead : bus.instrDataRead, vt[i].exp_rd);
        end

        tie(1'b0, 32'h55AA0005, 32'h55AA0006, "tie3");

        // Watchdog: slave never completes.
        @(posedge wb_clk_i); #1;
        s_hang = 1'b1;
        bus.instrWriteEnable = 1'b0; bus.instrAddress = 28'h0000200; bus.instrEnable = 1'b1;
        wait_ack(1'b0, 40, cyc, err, other);
        check("wdog ack_cycle",       cyc,                 32'd18);
        check("wdog error",           32'(err),            32'd1);
        check("wdog instrDataRead",   bus.instrDataRead,   32'hFFFFFFFF);
        check("wdog wbEnable_last",   32'(en_hist[17]),    32'd1);
        check("wdog wbEnable_done",   32'(en_hist[18]),    32'd0);
        s_hang = 1'b0;
        @(posedge wb_clk_i); #1;
        fresh = mk(1'b0, 1'b0, 28'h0000204, 4'hF, 32'h0, 32'h2468ACE0, 0, 4, 32'h2468ACE0);
        drive(fresh);
        wait_ack(1'b0, 40, cyc, err, other);
        check("post_wdog ack_cycle", cyc,               32'd4);
        check("post_wdog error",     32'(err),          32'd0);
        check("post_wdog rd",        bus.instrDataRead, 32'h2468ACE0);

        // Reset while ACTIVE.
        @(posedge wb_clk_i); #1;
        fresh = mk(1'b0, 1'b0, 28'h0000208, 4'hF, 32'h0, 32'h11111111, 3, 7, 32'h11111111);
        drive(fresh);
        repeat (3) @(posedge wb_clk_i);
        #1;
        check("rst wbEnable_active", 32'(bus.wbEnable), 32'd1);
        wb_rst_i = 1'b1;
        bus.instrEnable = 1'b0;
        @(posedge wb_clk_i); #1;
        check("rst wbEnable",      32'(bus.wbEnable), 32'd0);
        check("rst instrAck",      32'(bus.instrAck), 32'd0);
        check("rst instrDataRead", bus.instrDataRead, 32'hFFFFFFFF);
        wb_rst_i = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(posedge wb_clk_i); #1;
            if (bus.instrAck || bus.dataAck) seen = 1'b1;
        end
        check("rst no_late_ack", 32'(seen), 32'd0);
        fresh = mk(1'b0, 1'b0, 28'h000020C, 4'hF, 32'h0, 32'h13579BDF, 0, 4, 32'h13579BDF);
        drive(fresh);
        wait_ack(1'b0, 40, cyc, err, other);
        check("post_rst ack_cycle", cyc,               32'd4);
        check("post_rst rd",        bus.instrDataRead, 32'h13579BDF);

        // Data withdraws its request in START; pending instr request follows.
        @(posedge wb_clk_i); #1;
        bus.dataAddress = 28'h0000300; bus.instrAddress = 28'h0000400;
        bus.dataWriteEnable = 1'b0; bus.instrWriteEnable = 1'b0;
        s_resp = 32'h77778888; s_waits = 0;
        bus.dataEnable = 1'b1; bus.instrEnable = 1'b1;
        @(posedge wb_clk_i); #1;
        check("drop grant_addr", 32'(bus.wbAddress), 32'h0000300);
        check("drop wbEnable_c1", 32'(bus.wbEnable), 32'd1);
        bus.dataEnable = 1'b0;
        @(posedge wb_clk_i); #1;
        check("drop wbEnable_c2", 32'(bus.wbEnable), 32'd0);
        seen = bus.dataAck;
        cyc = 0;
        for (int unsigned c = 3; c <= 20; c++) begin
            @(posedge wb_clk_i); #1;
            if (c == 4) begin
                check("drop instr_addr", 32'(bus.wbAddress), 32'h0000400);
                check("drop instr_wbEnable", 32'(bus.wbEnable), 32'd1);
            end
            if (bus.dataAck) seen = 1'b1;
            if (bus.instrAck) begin
                cyc = c;
                bus.instrEnable = 1'b0;
                break;
            end
        end
        check("drop no_dataAck",     32'(seen),          32'd0);
        check("drop instr_ack",      cyc,                32'd7);
        check("drop instrDataRead",  bus.instrDataRead,  32'h77778888);
        check("drop dataDataRead",   bus.dataDataRead,   32'hFFFFFFFF);

        repeat (2) @(posedge wb_clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule
